des_key_sched_gen: RTL and testbench
====================================

// Module: des_key_sched_gen
// PURPOSE
//  Parametrised DES/3DES round-key generator: next generation of the single-key, encrypt-only key schedule.
//  Loads 1 or 3 64-bit keys and streams 16*NUM_KEYS 48-bit round keys over a valid/ready handshake.
//  Supports encrypt or decrypt ordering (right-rotating schedule for decrypt) and EDE pass sequencing for 3DES.
//  Sits between the key register file and the round datapath.
// PARAMETERS
//  NUM_KEYS    1       keys per job: 1 = DES, 3 = 3DES EDE. Any other value is an elaboration error.
//  SHIFT_SCHED 16'h7EFC  bit r-1 = 1: round r rotates by 2, else by 1. Default gives 1 for rounds 1,2,9,16.
// PORTS
//  clk        in   1            clock
//  rst_n      in   1            asynchronous active-low reset
//  start      in   1            job request; sampled only in IDLE
//  decrypt    in   1            mode, captured with start: 0 = encrypt order, 1 = decrypt order
//  key_in     in   64*NUM_KEYS  K1 in the MSBs [64*NUM_KEYS-1 -: 64]; key bit 1 (DES numbering) = MSB of each key
//  flush      in   1            synchronous abort of the job in flight
//  rk_ready   in   1            consumer accepts round_key
//  rk_valid   out  1            round_key valid
//  round_key  out  48           PC-2 output; DES bit 1 = round_key[47]
//  round_idx  out  4            round 0..15 of the current pass
//  pass_idx   out  2            pass 0..NUM_KEYS-1
//  pass_dec   out  1            current pass runs DES decryption direction
//  busy       out  1            job in flight
//  done       out  1            1-cycle pulse after the last round key is accepted
// BEHAVIOUR
//  Reset values: rk_valid=0, busy=0, done=0, round_idx=0, pass_idx=0, pass_dec=0, CD=0, key store=0.
//   round_key = PC2(0) = 0.
//  States:
//   IDLE -> EMIT on start (edge t). key_in and decrypt are registered; CD loads the round-1 state of pass 0.
//   rk_valid=1 from cycle t+1 (latency 1). start is ignored while busy.
//  Pass keys:
//   Encrypt: K1 enc, K2 dec, K3 enc.  Decrypt: K3 dec, K2 enc, K1 dec.
//   NUM_KEYS=1: a single pass, direction = decrypt.
//  Round-1 CD state:
//   Enc pass: rotl1(C0),rotl1(D0) of PC1(key).  Dec pass: PC1(key) unchanged (C16D16 = C0D0).
//  Advance: only on a handshake (rk_valid & rk_ready) at a clock edge.
//   Enc pass: round r -> r+1 rotates C and D left by shift(r+1).
//   Dec pass: round index i -> i+1 rotates right by shift(16-i), with i = 0-based round_idx.
//  round_key, round_idx, pass_idx and pass_dec are held stable while rk_valid & !rk_ready.
//  Pass boundary: a handshake on round_idx=15 of a non-last pass loads the next key's round-1 state.
//   No bubble: rk_valid stays high.
//  Handshake on round_idx=15 of the last pass:
//   -> IDLE; rk_valid=0 and busy=0 next cycle; done=1 for exactly that cycle.
//   start in the done cycle is accepted normally.
//  flush (any state): -> IDLE next edge, rk_valid=0, busy=0, no done pulse. flush beats a simultaneous start.
//  Async reset mid-job: everything returns to reset values immediately; no done pulse.
//  Parity bits (8,16,..,64) of each key are ignored by PC1.
//  Total handshakes per job = 16*NUM_KEYS.
// TESTING
//  1) NUM_KEYS=1, key 133457799BBCDFF1, decrypt=0, rk_ready=1: 16 keys in consecutive cycles.
//     First = 1B02EFFC7072, last = CB3D8B0E17F5; done 1 cycle after the last handshake.
//  2) Same key, decrypt=1: first = CB3D8B0E17F5, 16th = 1B02EFFC7072; exact reverse of scenario 1.
//  3) NUM_KEYS=3, K1=K2=K3=133457799BBCDFF1, encrypt: 48 keys with no gaps.
//     Pass 1 sequence is the reverse of pass 0; pass_dec = 0,1,0.
//  4) Random rk_ready stalls (50%): round_key and indices stable during stalls.
//     Sequence identical to scenario 3; exactly 48 handshakes.
//  5) flush at round 7 of pass 1: rk_valid=0 next cycle, done never pulses.
//     A new start then produces round 0 of pass 0 again.
//  6) rst_n low at round 5: all outputs 0 asynchronously; start while busy is ignored.
//     A start on the done cycle begins a new job.

Source files
------------

// File: rtl/des_key_sched_gen.sv
// DES/3DES round-key generator: loads 1 or 3 keys and streams 16*NUM_KEYS
// PC-2 round keys over valid/ready, in encrypt or decrypt (EDE) order.
module des_key_sched_gen #(
  parameter int          NUM_KEYS    = 1,
  parameter logic [15:0] SHIFT_SCHED = 16'h7EFC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  decrypt,
  input  logic [64*NUM_KEYS-1:0] key_in,
  input  logic                  flush,
  input  logic                  rk_ready,
  output logic                  rk_valid,
  output logic [47:0]           round_key,
  output logic [3:0]            round_idx,
  output logic [1:0]            pass_idx,
  output logic                  pass_dec,
  output logic                  busy,
  output logic                  done
);

  if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
    $error("des_key_sched_gen: NUM_KEYS must be 1 or 3");
  end

  localparam logic [1:0] LAST_PASS = 2'(NUM_KEYS - 1);

  // Tables hold DES bit numbers (1 = MSB) exactly as published.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r = {r[54:0], k[6'(64 - PC1_TAB[6'(i)])]};
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r = {r[46:0], cd[6'(56 - PC2_TAB[6'(i)])]};
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Decrypt passes start from C0D0, which equals C16D16 after the full 28-bit rotation.
  function automatic logic [55:0] round1_cd(input logic [63:0] key, input logic dec);
    logic [55:0] cd;
    cd = pc1(key);
    if (!dec) cd = {rotl(cd[55:28], 1'b0), rotl(cd[27:0], 1'b0)};
    return cd;
  endfunction

  function automatic logic [55:0] step_cd(input logic [55:0] cd, input logic dec,
                                          input logic [3:0] idx);
    logic [3:0] b;
    logic       two;
    b   = dec ? 4'd15 - idx : idx + 4'd1;
    two = SHIFT_SCHED[b];
    if (dec) return {rotr(cd[55:28], two), rotr(cd[27:0], two)};
    return {rotl(cd[55:28], two), rotl(cd[27:0], two)};
  endfunction

  function automatic logic [63:0] key_of(input logic [64*NUM_KEYS-1:0] keys,
                                         input logic [1:0] k);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < NUM_KEYS; n++)
      if (k == n[1:0]) r = keys[64*(NUM_KEYS-1-n) +: 64];
    return r;
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [64*NUM_KEYS-1:0]  r_keys;
  logic                    r_decrypt;
  logic [55:0]             r_cd;
  logic [3:0]              r_round;
  logic [1:0]              r_pass;
  logic                    r_pass_dec;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    w_hs, w_load, w_last_round, w_last_pass;
  logic [1:0]              w_pass_nxt, w_key_nxt;
  logic                    w_dec_nxt;
  logic [63:0]             w_start_key;

  assign w_hs         = (r_state == S_EMIT) && rk_ready;
  assign w_load       = (r_state == S_IDLE) && start && !flush;
  assign w_last_round = (r_round == 4'd15);
  assign w_last_pass  = (r_pass == LAST_PASS);
  assign w_pass_nxt   = r_pass + 2'd1;
  assign w_key_nxt    = r_decrypt ? LAST_PASS - w_pass_nxt : w_pass_nxt;
  assign w_dec_nxt    = r_decrypt ^ w_pass_nxt[0];
  assign w_start_key  = key_of(key_in, decrypt ? LAST_PASS : 2'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_state_nxt = S_EMIT;
        S_EMIT: if (w_hs && w_last_round && w_last_pass) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      endcase
    end
  end

  // NOTE: the key store is reset too, so no key material survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keys     <= '0;
      r_decrypt  <= 1'b0;
      r_cd       <= '0;
      r_round    <= '0;
      r_pass     <= '0;
      r_pass_dec <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (flush) begin
        r_round <= '0;
        r_pass  <= '0;
      end else if (w_load) begin
        r_keys     <= key_in;
        r_decrypt  <= decrypt;
        r_round    <= '0;
        r_pass     <= '0;
        r_pass_dec <= decrypt;
        r_cd       <= round1_cd(w_start_key, decrypt);
      end else if (w_hs) begin
        if (!w_last_round) begin
          r_round <= r_round + 4'd1;
          r_cd    <= step_cd(r_cd, r_pass_dec, r_round);
        end else if (!w_last_pass) begin
          r_round    <= '0;
          r_pass     <= w_pass_nxt;
          r_pass_dec <= w_dec_nxt;
          r_cd       <= round1_cd(key_of(r_keys, w_key_nxt), w_dec_nxt);
        end else begin
          r_round <= '0;
          r_pass  <= '0;
        end
      end
    end
  end

  assign rk_valid  = (r_state == S_EMIT);
  assign busy      = (r_state == S_EMIT);
  assign done      = r_done;
  assign round_key = pc2(r_cd);
  assign round_idx = r_round;
  assign pass_idx  = r_pass;
  assign pass_dec  = r_pass_dec;

endmodule

// File: tb/tb_des_key_sched_gen.sv
// Bench for des_key_sched_gen: DES (NUM_KEYS=1) and 3DES (NUM_KEYS=3) instances
// checked against the published subkeys of key 133457799BBCDFF1.
module tb_des_key_sched_gen;

  localparam logic [63:0] TKEY   = 64'h133457799BBCDFF1;
  localparam logic [1:0]  S_ENC  = 2'd0;
  localparam logic [1:0]  S_DEC  = 2'd1;
  localparam logic [1:0]  S_ZERO = 2'd2;
  localparam logic [1:0]  S_ONES = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start1, start3, decrypt, flush, rk_ready;
  logic [63:0]  key1;
  logic [191:0] key3;
  logic         valid1, busy1, done1, pd1, valid3, busy3, done3, pd3;
  logic [47:0]  rk1, rk3;
  logic [3:0]   ri1, ri3;
  logic [1:0]   pi1, pi3;

  des_key_sched_gen #(.NUM_KEYS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .decrypt(decrypt), .key_in(key1),
    .flush(flush), .rk_ready(rk_ready), .rk_valid(valid1), .round_key(rk1),
    .round_idx(ri1), .pass_idx(pi1), .pass_dec(pd1), .busy(busy1), .done(done1));

  des_key_sched_gen #(.NUM_KEYS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .decrypt(decrypt), .key_in(key3),
    .flush(flush), .rk_ready(rk_ready), .rk_valid(valid3), .round_key(rk3),
    .round_idx(ri3), .pass_idx(pi3), .pass_dec(pd3), .busy(busy3), .done(done3));

  logic        sel3;
  logic        m_valid, m_busy, m_done, m_pd;
  logic [47:0] m_rk;
  logic [3:0]  m_ri;
  logic [1:0]  m_pi;
  assign m_valid = sel3 ? valid3 : valid1;
  assign m_busy  = sel3 ? busy3  : busy1;
  assign m_done  = sel3 ? done3  : done1;
  assign m_pd    = sel3 ? pd3    : pd1;
  assign m_rk    = sel3 ? rk3    : rk1;
  assign m_ri    = sel3 ? ri3    : ri1;
  assign m_pi    = sel3 ? pi3    : pi1;

  typedef struct packed {
    logic [47:0] rk;
    logic [3:0]  ri;
    logic [1:0]  pi;
    logic        pd;
  } exp_t;

  typedef struct {
    bit              k3;
    logic            dec;
    logic [191:0]    key;
    int              stall;
    bit              poke;
    logic [2:0][1:0] src;
    logic [2:0]      pdec;
  } job_t;

  logic [47:0] kt [16];
  job_t        jobs [8];
  exp_t        q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] exp_rk(input logic [1:0] s, input int i);
    case (s)
      S_ENC:   return kt[i];
      S_DEC:   return kt[15-i];
      S_ZERO:  return '0;
      default: return '1;
    endcase
  endfunction

  // Starts a job on the selected instance at the current negedge and follows it to done.
  task automatic run_job(input job_t j);
    int   total, hs, cyc, gaps;
    logic rdy;
    exp_t e;
    sel3  = j.k3;
    total = j.k3 ? 48 : 16;
    for (int p = 0; p < total / 16; p++)
      for (int i = 0; i < 16; i++)
        q.push_back({exp_rk(j.src[p], i), 4'(i), 2'(p), j.pdec[p]});
    if (j.k3) begin key3 = j.key; start3 = 1'b1; end
    else      begin key1 = j.key[191 -: 64]; start1 = 1'b1; end
    decrypt  = j.dec;
    rk_ready = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    key1   = ~key1;
    key3   = ~key3;
    check("first_valid", 64'({m_valid, m_done}), 64'(2'b10));
    hs = 0; cyc = 0; gaps = 0;
    while (hs < total && cyc < 4000) begin
      if (!m_valid) gaps++;
      else begin
        e = q[0];
        check("round_key", 64'({m_rk, m_ri, m_pi, m_pd, m_busy}), 64'({e, 1'b1}));
      end
      if (j.poke && hs == 5) begin
        start1 = !j.k3; start3 = j.k3; decrypt = ~j.dec;
      end else begin
        start1 = 1'b0; start3 = 1'b0; decrypt = j.dec;
      end
      rdy = (j.stall == 0) || (int'($urandom_range(99)) >= j.stall);
      rk_ready = rdy;
      if (m_valid && rdy) begin
        void'(q.pop_front());
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    start1 = 1'b0; start3 = 1'b0; rk_ready = 1'b0;
    check("handshakes", 64'(hs), 64'(total));
    check("valid_gaps", 64'(gaps), 64'd0);
    check("done_pulse", 64'({m_done, m_valid, m_busy}), 64'(3'b100));
    q.delete();
  endtask

  initial begin
    int   cyc;
    logic seen;
    kt = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
           48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
           48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
           48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    jobs[0] = '{1'b0, 1'b0, {TKEY, 128'h0}, 0, 1'b0, {S_ENC, S_ENC, S_ENC}, 3'b000};
    jobs[1] = '{1'b0, 1'b1, {TKEY, 128'h0}, 0, 1'b0, {S_DEC, S_DEC, S_DEC}, 3'b001};
    jobs[2] = '{1'b0, 1'b0, {TKEY ^ 64'h0101010101010101, 128'h0}, 50, 1'b1,
                {S_ENC, S_ENC, S_ENC}, 3'b000};
    jobs[3] = '{1'b1, 1'b0, {TKEY, TKEY, TKEY}, 0, 1'b0, {S_ENC, S_DEC, S_ENC}, 3'b010};
    jobs[4] = '{1'b1, 1'b0, {TKEY, TKEY, TKEY}, 50, 1'b0, {S_ENC, S_DEC, S_ENC}, 3'b010};
    jobs[5] = '{1'b1, 1'b1, {TKEY, TKEY, TKEY}, 0, 1'b0, {S_DEC, S_ENC, S_DEC}, 3'b101};
    jobs[6] = '{1'b1, 1'b0, {TKEY, 64'h0, ~64'h0}, 30, 1'b0, {S_ONES, S_ZERO, S_ENC}, 3'b010};
    jobs[7] = '{1'b1, 1'b1, {TKEY, 64'h0, ~64'h0}, 0, 1'b1, {S_DEC, S_ZERO, S_ONES}, 3'b101};

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; decrypt = 1'b0; flush = 1'b0;
    rk_ready = 1'b0; key1 = TKEY; key3 = {TKEY, TKEY, TKEY}; sel3 = 1'b0;
    #3;
    check("reset_dut1", 64'({valid1, busy1, done1, rk1, ri1, pi1, pd1}), 64'd0);
    check("reset_dut3", 64'({valid3, busy3, done3, rk3, ri3, pi3, pd3}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back jobs: each start lands in the previous job's done cycle.
    for (int n = 0; n < 8; n++) run_job(jobs[n]);
    @(negedge clk);
    check("done_width", 64'(m_done), 64'd0);

    // Flush at round 7 of pass 1, then flush racing a start, then a clean restart.
    sel3 = 1'b1; key3 = {TKEY, TKEY, TKEY}; decrypt = 1'b0; start3 = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 0;
    while (!(m_pi == 2'd1 && m_ri == 4'd7) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("flush_point", 64'({m_rk, m_ri, m_pi, m_pd}), 64'({kt[8], 4'd7, 2'd1, 1'b1}));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 64'({m_valid, m_busy, m_done}), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | m_done | m_valid;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    start3 = 1'b1; flush = 1'b1;
    @(negedge clk);
    start3 = 1'b0; flush = 1'b0;
    check("flush_beats_start", 64'({m_valid, m_busy}), 64'd0);
    start3 = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    start3 = 1'b0;
    check("restart", 64'({m_valid, m_rk, m_ri, m_pi, m_pd}), 64'({1'b1, kt[0], 7'd0}));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    // Asynchronous reset in the middle of a DES job.
    sel3 = 1'b0; key1 = TKEY; decrypt = 1'b0; start1 = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (m_ri != 4'd5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset", 64'({m_valid, m_rk, m_ri}), 64'({1'b1, kt[5], 4'd5}));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 64'({valid1, busy1, done1, rk1, ri1, pi1, pd1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rk_ready = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done1 | valid1;
    end
    check("reset_no_done", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
